// File: rtl/conv3x3_row_engine_pkg.sv
// Shared definitions for the streaming 3x3 convolution row engine:
// controller states, kernel tap layout, accumulator sizing and the
// floor-shift/saturate helper used by every output pixel.
package conv3x3_row_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Kernel layout: tap r*3+c, row r=0 is the oldest line.
  localparam int TAP_ROWS   = 3;
  localparam int TAP_COLS   = 3;
  localparam int TAP_N      = TAP_ROWS * TAP_COLS;
  localparam int TAP_CENTER = 4;

  // Nine DATA_W x DATA_W products plus a bias need 2*DATA_W+5 signed bits.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 5;
  endfunction

  // Arithmetic (floor) right shift followed by clamp to a signed data_w range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int data_w);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/conv3x3_row_engine_if.sv
// Row-stream bundle of the convolution engine: weight/bias load, input
// row handshake, output row handshake with frame tag, and busy status.
// slave = engine side, master = row source / sink side.
interface conv3x3_row_engine_if
  import conv3x3_row_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IN_W   = 40,
  parameter int BIAS_W = 16
) ();

  logic                          load_i;
  logic [TAP_N*DATA_W-1:0]       weight_i;
  logic signed [BIAS_W-1:0]      bias_i;
  logic                          valid_i;
  logic                          ready_i;
  logic [IN_W*DATA_W-1:0]        data_i;
  logic                          valid_o;
  logic                          ready_o;
  logic [(IN_W-2)*DATA_W-1:0]    data_o;
  logic                          last_o;
  logic                          busy_o;

  modport slave (
    input  load_i, weight_i, bias_i, valid_i, data_i, ready_o,
    output ready_i, valid_o, data_o, last_o, busy_o
  );

  modport master (
    output load_i, weight_i, bias_i, valid_i, data_i, ready_o,
    input  ready_i, valid_o, data_o, last_o, busy_o
  );

endinterface

// File: rtl/conv3x3_row_engine_mac.sv
// One output pixel of the 3x3 convolution: nine registered products,
// adder tree with bias, then floor shift and saturation into the output
// register. Each stage advances only on its own enable.
// Optional build macro: RELU_EN (clamp negative results to zero).
module conv3x3_mac
  import conv3x3_row_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BIAS_W = 16,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_p0,
  input  logic                     en_p1,
  input  logic                     en_p2,
  input  logic [TAP_N*DATA_W-1:0]  win,
  input  logic [TAP_N*DATA_W-1:0]  weight,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [DATA_W-1:0] pix
);

  localparam int ACC_W = acc_w(DATA_W);
  localparam int PW    = 2 * DATA_W;

  logic signed [PW-1:0]     prod_d  [TAP_N];
  logic signed [PW-1:0]     prod_p0 [TAP_N];
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [63:0]       acc64;
  logic signed [DATA_W-1:0] sat_d;
  logic signed [DATA_W-1:0] pix_d;

  // Sign-extend pixel and weight to product width and multiply per tap.
  always_comb begin
    for (int t = 0; t < TAP_N; t++) begin
      prod_d[t] = $signed({{DATA_W{win[t*DATA_W+DATA_W-1]}}, win[t*DATA_W +: DATA_W]})
                * $signed({{DATA_W{weight[t*DATA_W+DATA_W-1]}}, weight[t*DATA_W +: DATA_W]});
    end
  end

  // ---- stage 1: product registers ----
  always_ff @(posedge clk) begin
    if (en_p0) begin
      for (int t = 0; t < TAP_N; t++) prod_p0[t] <= prod_d[t];
    end
  end

  // Sum the nine products on top of the sign-extended bias.
  always_comb begin
    sum_d = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    for (int t = 0; t < TAP_N; t++) begin
      sum_d = sum_d + {{(ACC_W-PW){prod_p0[t][PW-1]}}, prod_p0[t]};
    end
  end

  // ---- stage 2: accumulator register ----
  always_ff @(posedge clk) begin
    if (en_p1) acc_p1 <= sum_d;
  end

  // Floor shift, saturate and optionally rectify the accumulator.
  always_comb begin
    acc64 = {{(64-ACC_W){acc_p1[ACC_W-1]}}, acc_p1};
    sat_d = DATA_W'(shift_sat(acc64, SHIFT, DATA_W));
`ifdef RELU_EN
    pix_d = (sat_d < 0) ? '0 : sat_d;
`else
    pix_d = sat_d;
`endif
  end

  // ---- stage 3: output pixel register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pix <= '0;
    else if (en_p2) pix <= pix_d;
  end

endmodule

// File: rtl/conv3x3_row_engine.sv
// Streaming 3x3 convolution layer: one input row per beat, two-row line
// buffer, frame row counting, 3-stage MAC pipeline with full ready/valid
// backpressure. Optional build macro: RELU_EN (non-negative outputs).
module conv3x3_row_engine
  import conv3x3_row_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IN_W   = 40,
  parameter int IN_H   = 40,
  parameter int BIAS_W = 16,
  parameter int SHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv3x3_row_engine_if.slave   bus
);

  localparam int OUT_N = IN_W - 2;
  localparam int CNT_W = $clog2(IN_H);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IN_H - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
  logic                      wt_load, last_row;
  logic [TAP_N*DATA_W-1:0]   weight_q;
  logic signed [BIAS_W-1:0]  bias_q;
  logic [IN_W*DATA_W-1:0]    lb0_q, lb1_q;
  logic [IN_W*DATA_W-1:0]    rows [TAP_ROWS];
  logic                      vld_p0, vld_p1, vld_p2;
  logic                      last_p0, last_p1, last_p2;
  logic                      stall, fire, fire_run, pipe_busy;
  logic [OUT_N*DATA_W-1:0]   data_p2;

  assign stall     = vld_p2 && !bus.ready_o;
  assign fire      = bus.valid_i && bus.ready_i;
  assign fire_run  = fire && (state_q == RUN);
  assign pipe_busy = vld_p0 || vld_p1 || vld_p2;

  assign bus.ready_i = (state_q != IDLE) && !stall;
  assign bus.valid_o = vld_p2;
  assign bus.last_o  = last_p2;
  assign bus.data_o  = data_p2;
  assign bus.busy_o  = (state_q != IDLE) || (row_cnt_q != '0) || pipe_busy;

  // Controller state and frame row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Next state, row count, weight-load permission and end-of-frame tag.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    wt_load   = 1'b0;
    last_row  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_i) begin
          wt_load   = 1'b1;
          row_cnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (fire) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == CNT_W'(1)) state_d = RUN;
        end else if (bus.load_i && (row_cnt_q == '0) && !pipe_busy) begin
          wt_load = 1'b1;
        end
      end
      RUN: begin
        if (fire) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = FILL;
            last_row  = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Kernel and bias capture; only between frames with an empty pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      bias_q   <= '0;
    end else if (wt_load) begin
      weight_q <= bus.weight_i;
      bias_q   <= bus.bias_i;
    end
  end

  // Two-row line buffer: lb0 holds the oldest accepted row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb0_q <= '0;
      lb1_q <= '0;
    end else if (fire) begin
      lb0_q <= lb1_q;
      lb1_q <= bus.data_i;
    end
  end

  // Valid and last tag travel with the data; the whole pipe freezes on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p0  <= fire_run;
      last_p0 <= fire_run && last_row;
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 && last_p1;
    end
  end

  assign rows[0] = lb0_q;
  assign rows[1] = lb1_q;
  assign rows[2] = bus.data_i;

  for (genvar j = 0; j < OUT_N; j++) begin : g_mac
    logic [TAP_N*DATA_W-1:0] win;

    for (genvar r = 0; r < TAP_ROWS; r++) begin : g_row
      for (genvar c = 0; c < TAP_COLS; c++) begin : g_col
        assign win[(r*TAP_COLS+c)*DATA_W +: DATA_W] = rows[r][(j+c)*DATA_W +: DATA_W];
      end
    end

    conv3x3_mac #(
      .DATA_W (DATA_W),
      .BIAS_W (BIAS_W),
      .SHIFT  (SHIFT)
    ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_p0  (fire_run),
      .en_p1  (vld_p0 && !stall),
      .en_p2  (vld_p1 && !stall),
      .win    (win),
      .weight (weight_q),
      .bias   (bias_q),
      .pix    (data_p2[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/conv3x3_row_engine.md
Name: conv3x3_row_engine

Overview:
Parametrised streaming 3x3 convolution layer. Generalises the fixed-width conv2 wrapper: image width, height, data width and output scaling are configurable. Adds an internal two-row line buffer, full ready/valid backpressure and frame tracking. It sits between the feature-map row source and the pooling/output register stage, and consumes one input row per beat.

Parameters:
DATA_W, 8, signed pixel and weight width
IN_W, 40, input row width in pixels (>=3)
IN_H, 40, input rows per frame (>=3)
BIAS_W, 16, signed bias width (must be <= 2*DATA_W+4)
SHIFT, 4, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_i  in  1  weight/bias capture strobe
weight_i  in  9*DATA_W  kernel; tap r*3+c at [(r*3+c)*DATA_W +: DATA_W]; r=0 is the oldest row
bias_i  in  BIAS_W  signed bias
valid_i  in  1  input row valid
ready_i  out  1  input row accepted when valid_i&&ready_i
data_i  in  IN_W*DATA_W  pixel k at [k*DATA_W +: DATA_W]
valid_o  out  1  output row valid
ready_o  in  1  downstream ready
data_o  out  (IN_W-2)*DATA_W  output pixel j at [j*DATA_W +: DATA_W]
last_o  out  1  qualifies final output row of a frame
busy_o  out  1  high when the state is not IDLE, or a frame is in progress, or the pipeline holds data

Behaviour:
- Single clock domain; reset is asynchronous and active-low on rst_n. Reset values: all outputs 0, state IDLE, row counter 0, pipeline valids 0, weight/bias registers 0, line buffer 0.
- Reset mid-frame discards all partial state. After reset, load_i is required again.
- States:
  - IDLE: ready_i=0. load_i captures weight_i/bias_i, then go to FILL.
  - FILL: row_cnt<2. Accepted rows shift into the line buffer; no output is produced.
  - RUN: each accepted row forms the window {lb0, lb1, data_i} and issues one output row.
- Row counting: row_cnt increments per accepted row. On acceptance of row IN_H-1, row_cnt returns to 0, state goes to FILL, and that output row carries last tag=1.
- Weight reload: load_i in FILL with row_cnt==0 and no pipeline valids reloads weights and bias. Otherwise load_i is ignored; weights never change mid-frame.
- Arithmetic: out[j] = sat_DATA_W((sum over r,c of w[r*3+c]*px_r[j+c] + sext(bias)) >>> SHIFT).
  - Accumulator width ACC_W = 2*DATA_W+5, signed.
  - Shift is floor (arithmetic) with no rounding.
  - Saturation limits: max 2^(DATA_W-1)-1, min -2^(DATA_W-1).
- Pipeline: 3 stages.
  - S1: registered products.
  - S2: adder tree plus bias.
  - S3: shift and saturate into the output register.
  - Latency is 3 cycles from the accepted RUN beat to valid_o, with ready_o held high.
  - Throughput is one row per cycle.
- Handshake:
  - stall = valid_o && !ready_o; all stages and the line buffer freeze while stall is high.
  - ready_i = (state!=IDLE) && !stall.
  - data_o/last_o are held stable while valid_o && !ready_o.
  - valid_o drops after the handshake unless a new S3 result arrives in the same cycle.
- Simultaneous events: load_i together with an accepted valid_i is ignored. The final row of frame N may be followed by row 0 of frame N+1 on the next cycle with no bubble.

Optional Feature:
RELU_EN. When defined, S3 clamps negative saturated results to 0, so data_o is never negative. When not defined, signed saturated results pass through unchanged.

Decomposition:
- Package conv_pkg:
  - ACC_W function
  - sat/shift helper function
  - state enum (IDLE, FILL, RUN)
  - tap-index constants
- One natural sub-module is conv3x3_mac: one output pixel's 9 products, adder tree, bias, shift and saturate, with stage enables. It is instantiated IN_W-2 times via generate.

Test Plan:
- Identity kernel: load w[4]=16, others 0, bias 0, SHIFT=4; stream rows with all pixels = row index 0..39. Output row m must have all pixels = m+1; 38 rows; last_o only on the 38th; latency 3.
- Saturation: all weights 127, pixels 127, bias 0 -> all outputs 127. Same kernel with pixels -128 -> -128, or 0 with RELU_EN.
- Bias/shift: zero weights, bias=-40 -> outputs -3 (floor of -2.5). bias=40 -> 2.
- Backpressure: hold ready_o=0 for 5 cycles mid-frame. Required: ready_i=0, data_o stable, no lost or duplicated rows; the sequence must match the ready_o=1 run.
- Frame boundary: IN_H=4; send 8 rows back-to-back -> 4 output rows with last_o on rows 2 and 4. load_i at row 2 is ignored; load_i between frames with the pipeline empty takes effect.
- Reset mid-frame: assert rst_n=0 after row 10 -> all outputs 0 immediately and ready_i=0. Without load_i, ready_i stays 0; after load_i, FILL restarts.
